hi_iso15693_cmd_encoder: RTL

//   ISO 15693 reader-command encoder: accepts command bytes and emits the 1-of-4 pulse-position

---
 rtl/iso15693_tx_pkg.sv | 42 ++++
 rtl/hi_iso15693_cmd_encoder_if.sv | 22 ++
 rtl/iso15693_slot_timer.sv | 35 +++
 rtl/hi_iso15693_cmd_encoder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/iso15693_tx_pkg.sv
// ISO 15693 reader-command encoder: shared states, frame patterns and slot counts.
// Also holds the per-slot pause rule used by the encoder datapath.
package iso15693_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_EOF
  } state_t;

  localparam logic [7:0] SOF_PATTERN = 8'h84;
  localparam logic [3:0] EOF_PATTERN = 4'h2;

  localparam int SOF_SLOTS     = 8;
  localparam int SYM_SLOTS     = 8;
  localparam int EOF_SLOTS     = 4;
  localparam int SYMS_PER_BYTE = 4;

  localparam logic [2:0] SOF_LAST     = 3'(SOF_SLOTS - 1);
  localparam logic [2:0] SYM_LAST     = 3'(SYM_SLOTS - 1);
  localparam logic [2:0] EOF_LAST     = 3'(EOF_SLOTS - 1);
  localparam logic [1:0] SYM_IDX_LAST = 2'(SYMS_PER_BYTE - 1);

  // Patterns are MSB-first: bit 7 (SOF) / bit 3 (EOF) is slot 0.
  function automatic logic slot_has_pause(
    input state_t     st,
    input logic [2:0] slot,
    input logic [1:0] sym
  );
    logic p;
    p = 1'b0;
    unique case (st)
      ST_SOF:  p = SOF_PATTERN[3'd7 - slot];
      ST_DATA: p = (slot == {sym, 1'b1});
      ST_EOF:  p = EOF_PATTERN[2'd3 - slot[1:0]];
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/hi_iso15693_cmd_encoder_if.sv
// Command-byte handshake into the ISO 15693 encoder.
// master offers bytes, slave (the encoder) returns tx_ready.
interface hi_iso15693_cmd_encoder_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );
endinterface

// File: rtl/iso15693_slot_timer.sv
// Carrier-cycle slot counter with end-of-slot strobe and pause window.
// pause_nxt describes the cycle that follows, to feed a registered output.
module iso15693_slot_timer #(
  parameter int SLOT_CYCLES  = 128,
  parameter int PAUSE_CYCLES = 128
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic slot_end,
  output logic pause_nxt
);

  localparam int CW  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int CW1 = CW + 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(SLOT_CYCLES - 1);
  localparam logic [CW:0]   PAUSE_LIM = CW1'(PAUSE_CYCLES);

  logic [CW-1:0] slot_cnt;
  logic [CW-1:0] cnt_d;

  assign slot_end  = en && (slot_cnt == CNT_MAX);
  assign cnt_d     = (!en || slot_end) ? '0 : slot_cnt + CW'(1);
  assign pause_nxt = {1'b0, cnt_d} < PAUSE_LIM;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/hi_iso15693_cmd_encoder.sv
// ISO 15693 1-of-4 PPM command encoder: SOF + bytes + EOF onto mod_out.
// mod_out is loaded from next-cycle state so it lines up with busy/frame_done.
module hi_iso15693_cmd_encoder
  import iso15693_tx_pkg::*;
#(
  parameter int SLOT_CYCLES  = 128,
  parameter int PAUSE_CYCLES = 128
) (
  input  logic ck_1356meg,
  input  logic reset,
  hi_iso15693_cmd_encoder_if.slave tx,
  output logic mod_out,
  output logic busy,
  output logic frame_done,
  output logic underrun_err
);

  state_t     state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [1:0] sym_q, sym_d;
  logic [7:0] cur_q, cur_d;
  logic       cur_last_q, cur_last_d;
  logic [7:0] nxt_q, nxt_d;
  logic       nxt_full_q, nxt_full_d;
  logic       nxt_last_q, nxt_last_d;
  logic       last_seen_q, last_seen_d;
  logic       rdy_en_q;
  logic       mod_d;

  logic en, slot_end, pause_nxt;
  logic in_frame, sof_end, sym_end, byte_end, eof_end;
  logic load_edge, ready, accept;

  assign en = (state_q != ST_IDLE);

  iso15693_slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .PAUSE_CYCLES (PAUSE_CYCLES)
  ) u_timer (
    .clk       (ck_1356meg),
    .reset     (reset),
    .en        (en),
    .slot_end  (slot_end),
    .pause_nxt (pause_nxt)
  );

  assign in_frame  = (state_q == ST_SOF) || (state_q == ST_DATA);
  assign sof_end   = (state_q == ST_SOF) && slot_end && (slot_q == SOF_LAST);
  assign sym_end   = (state_q == ST_DATA) && slot_end && (slot_q == SYM_LAST);
  assign byte_end  = sym_end && (sym_q == SYM_IDX_LAST);
  assign eof_end   = (state_q == ST_EOF) && slot_end && (slot_q == EOF_LAST);
  assign load_edge = sof_end || byte_end;

  // On a byte boundary the next buffer is vacated this cycle, so a full
  // buffer can take a new byte; an empty one means underrun, not refill.
  assign ready = rdy_en_q && ((state_q == ST_IDLE) ||
                 (in_frame && !last_seen_q &&
                  (load_edge ? nxt_full_q : !nxt_full_q)));

  assign tx.tx_ready = ready;
  assign accept      = tx.tx_valid && ready;
  assign busy        = en;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    sym_d        = sym_q;
    cur_d        = cur_q;
    cur_last_d   = cur_last_q;
    nxt_d        = nxt_q;
    nxt_full_d   = nxt_full_q;
    nxt_last_d   = nxt_last_q;
    last_seen_d  = last_seen_q;
    frame_done   = 1'b0;
    underrun_err = 1'b0;

    if (slot_end) slot_d = slot_q + 3'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SOF;
          slot_d  = '0;
        end
      end
      ST_SOF: begin
        if (sof_end) begin
          state_d = ST_DATA;
          slot_d  = '0;
          sym_d   = '0;
        end
      end
      ST_DATA: begin
        if (sym_end) begin
          slot_d = '0;
          sym_d  = sym_q + 2'd1;
          cur_d  = {2'b00, cur_q[7:2]};
          if (byte_end && (cur_last_q || !nxt_full_q)) begin
            state_d      = ST_EOF;
            underrun_err = !cur_last_q;
          end
        end
      end
      ST_EOF: begin
        if (eof_end) begin
          state_d    = ST_IDLE;
          slot_d     = '0;
          frame_done = 1'b1;
        end
      end
      default: ;
    endcase

    if (load_edge && (state_d == ST_DATA)) begin
      cur_d      = nxt_q;
      cur_last_d = nxt_last_q;
      nxt_full_d = 1'b0;
    end

    if (accept) begin
      nxt_d       = tx.tx_data;
      nxt_full_d  = 1'b1;
      nxt_last_d  = tx.tx_last;
      last_seen_d = tx.tx_last;
    end

    mod_d = !(slot_has_pause(state_d, slot_d, cur_d[1:0]) && pause_nxt);
  end

  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      sym_q       <= '0;
      cur_q       <= '0;
      cur_last_q  <= 1'b0;
      nxt_q       <= '0;
      nxt_full_q  <= 1'b0;
      nxt_last_q  <= 1'b0;
      last_seen_q <= 1'b0;
      rdy_en_q    <= 1'b0;
      mod_out     <= 1'b1;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      sym_q       <= sym_d;
      cur_q       <= cur_d;
      cur_last_q  <= cur_last_d;
      nxt_q       <= nxt_d;
      nxt_full_q  <= nxt_full_d;
      nxt_last_q  <= nxt_last_d;
      last_seen_q <= last_seen_d;
      rdy_en_q    <= 1'b1;
      mod_out     <= mod_d;
    end
  end

endmodule
